// File: rtl/ttseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ttseq_pkg
//  Description : Shared types and constants for the truth-table sequencer:
//                FSM state encoding, settle-counter width, default input count
//                and a helper for sizing the mismatch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ttseq_pkg;

    localparam int SETTLE_W     = 4;
    localparam int N_IN_DEFAULT = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } state_e;

    // Counter width able to hold every vector mismatching (no wrap).
    function automatic int count_w(input int n_in);
        return $clog2((1 << n_in) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sequencer_if
//  Description : Host-side start/done handshake bundle of the sequencer:
//                golden table in, captured table and verdict out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_sequencer_if
    import ttseq_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
);
    localparam int NV = 1 << N_IN;
    localparam int CW = count_w(N_IN);

    logic          start;
    logic [NV-1:0] expected;
    logic          busy;
    logic          done;
    logic [NV-1:0] result;
    logic [CW-1:0] mismatch_count;
    logic          pass;

    modport master (
        output start, expected,
        input  busy, done, result, mismatch_count, pass
    );

    modport slave (
        input  start, expected,
        output busy, done, result, mismatch_count, pass
    );

endinterface
`default_nettype wire

// File: rtl/ttseq_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ttseq_settle_timer
//  Description : 4-bit down-counter timing how long each vector is held.
//                load arms it for SETTLE cycles; expire is high during the
//                last of those cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ttseq_settle_timer
    import ttseq_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic load,
    input  wire logic en,
    output logic      expire
);

    // Loading SETTLE-1 makes the count reach zero in the SETTLE-th cycle.
    localparam logic [SETTLE_W-1:0] C_LOAD = SETTLE_W'(SETTLE - 1);

    logic [SETTLE_W-1:0] r_cnt;

    // Reload on entry to a new vector, otherwise count down to zero and stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= C_LOAD;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sequencer
//  Description : Sweeps a combinational network through all 2**N_IN input
//                vectors, holds each for SETTLE cycles, samples the output
//                and compares it against a latched golden truth table.
//                Build option TTSEQ_STOP_ON_FAIL_EN ends the sweep at the
//                first mismatching vector and leaves it on drive.
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer
    import ttseq_pkg::*;
#(
    parameter int N_IN   = N_IN_DEFAULT,
    parameter int SETTLE = 2
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    truth_table_sequencer_if.slave   host,
    input  wire logic                sample,
    output logic [N_IN-1:0]          drive
);

    localparam int              NV     = 1 << N_IN;
    localparam int              CW     = count_w(N_IN);
    localparam logic [N_IN-1:0] C_LAST = N_IN'(NV - 1);

    state_e        r_state;
    logic [N_IN-1:0] r_idx;
    logic [NV-1:0] r_exp;
    logic [NV-1:0] r_result;
    logic [CW-1:0] r_mm;
    logic          r_pass;

    logic          w_miss;
    logic          w_last;
    logic          w_stop;
    logic          w_load;
    logic          w_expire;
    logic [CW-1:0] w_mm_next;

    assign w_miss    = (sample != r_exp[r_idx]);
    assign w_last    = (r_idx == C_LAST);
    assign w_mm_next = r_mm + CW'(w_miss);

`ifdef TTSEQ_STOP_ON_FAIL_EN
    assign w_stop = w_last || w_miss;
`else
    assign w_stop = w_last;
`endif

    // The timer is rearmed whenever a fresh vector is about to be applied.
    assign w_load = ((r_state == S_IDLE) && host.start) ||
                    ((r_state == S_SAMPLE) && !w_stop);

    ttseq_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .en     (r_state == S_SETTLE),
        .expire (w_expire)
    );

    // Sweep control: accept start, step vectors, capture samples, report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_exp    <= '0;
            r_result <= '0;
            r_mm     <= '0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (host.start) begin
                        r_exp    <= host.expected;
                        r_result <= '0;
                        r_mm     <= '0;
                        r_pass   <= 1'b0;
                        r_idx    <= '0;
                        r_state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_expire) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_result[r_idx] <= sample;
                    r_mm            <= w_mm_next;
                    if (w_stop) begin
                        // Verdict uses the count including this sample so it
                        // is already valid while done is high.
                        r_pass  <= (w_mm_next == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign drive               = r_idx;
    assign host.busy           = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign host.done           = (r_state == S_DONE);
    assign host.result         = r_result;
    assign host.mismatch_count = r_mm;
    assign host.pass           = r_pass;

endmodule
`default_nettype wire
